divmod_unit: RTL and testbench

//  Parametrised sequential integer divider returning quotient and remainder.

---
 rtl/divmod_pkg.sv | 14 +
 rtl/divmod_step.sv | 27 ++
 rtl/divmod_unit.sv | 122 ++++++++++++
 tb/tb_divmod_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/divmod_pkg.sv
// Shared definitions for the sequential divider.
// State encoding and default operand width.
package divmod_pkg;

   localparam int DIVMOD_WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/divmod_step.sv
// One radix-2 restoring iteration: shift in the next dividend
// bit, trial-subtract |B|, keep or restore the partial remainder.
module divmod_step
   import divmod_pkg::*;
#(
   parameter int WIDTH = DIVMOD_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             quo_msb,
   input  logic [WIDTH-1:0] abs_b,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   assign shifted = {rem, quo_msb};
   assign trial   = shifted - {1'b0, abs_b};

   // A clear top bit means the trial subtraction did not borrow.
   always_comb begin
      q_bit    = ~trial[WIDTH];
      rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   end

endmodule

// File: rtl/divmod_unit.sv
// Sequential shift-subtract divider returning quotient and
// remainder, signed or unsigned, with divide-by-zero flagging.
module divmod_unit
   import divmod_pkg::*;
#(
   parameter int WIDTH = DIVMOD_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_W   = CNT_W'(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] absb_q;
   logic [CNT_W-1:0] cnt;
   logic             neg_q;
   logic             neg_r;
   logic             zero_q;

   logic             sign_a;
   logic             sign_b;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH-1:0] rem_nx;
   logic             q_bit;

   // Operand magnitudes; sign bits only matter in signed mode.
   always_comb begin
      sign_a = signed_mode & dividend[WIDTH-1];
      sign_b = signed_mode & divisor[WIDTH-1];
      abs_a  = sign_a ? (~dividend + ONE) : dividend;
      abs_b  = sign_b ? (~divisor + ONE) : divisor;
   end

   divmod_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem      (rem_q),
      .quo_msb  (quo_q[WIDTH-1]),
      .abs_b    (absb_q),
      .rem_next (rem_nx),
      .q_bit    (q_bit)
   );

   // Control FSM with datapath registers and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         absb_q      <= '0;
         cnt         <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
                  neg_q       <= sign_a ^ sign_b;
                  neg_r       <= sign_a;
                  rem_q       <= '0;
                  quo_q       <= abs_a;
                  absb_q      <= abs_b;
                  cnt         <= C_W;
                  if (divisor == '0) begin
                     quotient  <= '1;
                     remainder <= dividend;
                     zero_q    <= 1'b1;
                     state     <= DONE;
                  end else begin
                     zero_q <= 1'b0;
                     state  <= CALC;
                  end
               end
            end
            CALC: begin
               rem_q <= rem_nx;
               quo_q <= {quo_q[WIDTH-2:0], q_bit};
               cnt   <= cnt - C_ONE;
               if (cnt == C_ONE) state <= FIX;
            end
            FIX: begin
               quotient  <= neg_q ? (~quo_q + ONE) : quo_q;
               remainder <= neg_r ? (~rem_q + ONE) : rem_q;
               state     <= DONE;
            end
            DONE: begin
               done        <= 1'b1;
               busy        <= 1'b0;
               div_by_zero <= zero_q;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divmod_unit.sv
// Directed and model-based checks for divmod_unit at WIDTH=32.
// Latency counted in rising edges after the accept edge.
module tb_divmod_unit;

   localparam int W = 32;
   localparam logic [W-1:0] MIN = 32'h8000_0000;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         signed_mode = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int checks = 0;
   int failures = 0;

   divmod_unit #(
      .WIDTH (W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .signed_mode (signed_mode),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called #1 after a rising edge; the next edge accepts.
   task automatic launch(input logic sm,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b);
      signed_mode = sm;
      dividend    = a;
      divisor     = b;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start       = 1'b0;
      dividend    = $urandom;
      divisor     = $urandom;
      signed_mode = $urandom_range(0, 1);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic op(input string tag,
                     input logic sm,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic [W-1:0] eq,
                     input logic [W-1:0] er,
                     input logic ez,
                     input int elat);
      int lat;
      launch(sm, a, b);
      wait_done(lat);
      check({tag, "_lat"}, W'(lat), W'(elat));
      check({tag, "_q"}, quotient, eq);
      check({tag, "_r"}, remainder, er);
      check({tag, "_z"}, W'(div_by_zero), W'(ez));
   endtask

   function automatic void model(input logic sm,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 output logic [W-1:0] q,
                                 output logic [W-1:0] r);
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sb;
      sa = a;
      sb = b;
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (!sm) begin
         q = a / b;
         r = a % b;
      end else if (a == MIN && b == '1) begin
         q = MIN;
         r = '0;
      end else begin
         q = sa / sb;
         r = sa % sb;
      end
   endfunction

   initial begin
      int lat;
      logic seen;
      logic [W-1:0] a, b, eq, er;
      logic sm;

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", W'(busy), '0);
      check("rst_done", W'(done), '0);
      check("rst_q", quotient, '0);
      check("rst_r", remainder, '0);
      check("rst_z", W'(div_by_zero), '0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
      op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
      op("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE,
         32'hFFFF_FFFD, 32'd1, 1'b0, 34);
      op("uF9_2", 1'b0, 32'hFFFF_FFF9, 32'd2,
         32'h7FFF_FFFC, 32'd1, 1'b0, 34);

      op("dz", 1'b1, 32'h1234, 32'd0,
         32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
      launch(1'b0, 32'd20, 32'd4);
      check("dz_clear", W'(div_by_zero), '0);
      check("busy_acc", W'(busy), 32'd1);
      wait_done(lat);
      check("u20_4_q", quotient, 32'd5);
      check("u20_4_r", remainder, 32'd0);

      op("ovf", 1'b1, MIN, 32'hFFFF_FFFF, MIN, 32'd0, 1'b0, 34);
      op("dz_u", 1'b0, MIN, 32'd0, 32'hFFFF_FFFF, MIN, 1'b1, 1);

      // Start re-pulsed mid-operation must be ignored.
      launch(1'b0, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #1;
      check("busy_mid", W'(busy), 32'd1);
      signed_mode = 1'b0;
      dividend    = 32'd50;
      divisor     = 32'd5;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 0;
      for (int n = 11; n <= 200; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            break;
         end
      end
      check("ign_lat", W'(lat), 32'd34);
      check("ign_q", quotient, 32'd14);
      check("ign_r", remainder, 32'd2);
      check("done_busy", W'(busy), '0);
      op("b2b", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

      // Reset in the middle of CALC.
      launch(1'b0, 32'd1000, 32'd7);
      repeat (15) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("mrst_busy", W'(busy), '0);
      check("mrst_q", quotient, '0);
      check("mrst_r", remainder, '0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      check("mrst_nodone", W'(seen), '0);
      op("post_rst", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

      // Model comparison over mixed operands.
      for (int i = 0; i < 200; i++) begin
         sm = i[0];
         a  = $urandom;
         unique case (i % 5)
            0: b = 32'($urandom_range(1, 15));
            1: b = $urandom;
            2: b = '1;
            3: b = (i % 7 == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            default: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
         endcase
         if (i % 23 == 0) a = MIN;
         model(sm, a, b, eq, er);
         op($sformatf("rnd%0d", i), sm, a, b, eq, er, b == '0,
            (b == '0) ? 1 : 34);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
